// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register offsets, TAC fields and channel state for timer_multi
package timer_pkg;

  // Register offsets within one channel's 4-byte window (cpu_addr[1:0])
  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  // TAC field positions
  localparam int TAC_EN     = 2;
  localparam int TAC_SEL_HI = 1;
  localparam int TAC_SEL_LO = 0;

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one TIMA/TMA/TAC timer channel with delayed overflow reload
//
// Counts on the falling edge of the enabled, selected system-counter tap.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   taps[3:0]           next-state system counter bits for TAC[1:0] = 0..3
//   tima_wr/tma_wr/tac_wr  single-clk write strobes for this channel
//   cpu_di[7:0]         write data
//   tima, tma, tac      register contents for the read mux
//   irq                 one-clk pulse during the reload clk
module timer_channel
  import timer_pkg::*;
#(
  parameter int RELOAD_DLY = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] taps,
  input  logic       tima_wr,
  input  logic       tma_wr,
  input  logic       tac_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] tima,
  output logic [7:0] tma,
  output logic [2:0] tac,
  output logic       irq
);

  localparam int CNT_W = (RELOAD_DLY > 1) ? $clog2(RELOAD_DLY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOAD_DLY - 1);

  ch_state_t        state, state_nx;
  logic [7:0]       tima_nx, tma_nx;
  logic [2:0]       tac_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             s, s_q, inc;

  // The tap level is taken from next-state sys/tac so that a DIV clear or a
  // TAC rewrite pulling the gated tap low produces an increment, exactly as
  // the AND-gate/falling-edge detector on the original hardware does.
  assign tac_nx = tac_wr ? cpu_di[2:0] : tac;
  assign s      = tac_nx[TAC_EN] & taps[tac_nx[TAC_SEL_HI:TAC_SEL_LO]];
  assign inc    = s_q & ~s;
  assign irq    = (state == RELOAD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= COUNT;
      tima  <= 8'h00;
      tma   <= 8'h00;
      tac   <= 3'b000;
      cnt   <= '0;
      s_q   <= 1'b0;
    end else begin
      state <= state_nx;
      tima  <= tima_nx;
      tma   <= tma_nx;
      tac   <= tac_nx;
      cnt   <= cnt_nx;
      s_q   <= s;
    end
  end

  always_comb begin
    state_nx = state;
    tima_nx  = tima;
    tma_nx   = tma_wr ? cpu_di : tma;
    cnt_nx   = cnt;
    case (state)
      COUNT: begin
        if (tima_wr) begin
          tima_nx = cpu_di;
        end else if (inc) begin
          if (tima == 8'hFF) begin
            tima_nx  = 8'h00;
            cnt_nx   = CNT_INIT;
            state_nx = OVF;
          end else begin
            tima_nx = tima + 8'd1;
          end
        end
      end
      OVF: begin
        // A CPU write during the 00 window cancels the pending reload.
        if (tima_wr) begin
          tima_nx  = cpu_di;
          state_nx = COUNT;
        end else if (cnt == '0) begin
          tima_nx  = tma;
          state_nx = RELOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RELOAD: begin
        // TIMA writes are swallowed here; a TMA write lands in both registers.
        state_nx = COUNT;
        if (tma_wr) tima_nx = cpu_di;
      end
      default: state_nx = COUNT;
    endcase
  end

endmodule

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - shared DIV counter plus NUM_CH Game Boy style timer channels
//
// Ports:
//   clk, reset_n   4 MHz CPU clock, asynchronous active-low reset
//   cpu_sel        register block selected
//   cpu_addr       [1:0] register (DIV/TIMA/TMA/TAC), upper bits channel
//   cpu_wr         single-clk write strobe
//   cpu_di         write data
//   cpu_do         combinational read data (FF for absent channels)
//   irq[NUM_CH]    per-channel one-clk overflow pulse
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH     = 1,
  parameter int DIV_W      = 16,
  parameter int TAP0       = 9,
  parameter int TAP1       = 3,
  parameter int TAP2       = 5,
  parameter int TAP3       = 7,
  parameter int RELOAD_DLY = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_sel,
  input  logic [1+$clog2(NUM_CH):0]    cpu_addr,
  input  logic                         cpu_wr,
  input  logic [7:0]                   cpu_di,
  output logic [7:0]                   cpu_do,
  output logic [NUM_CH-1:0]            irq
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = 2 + CH_W;
  localparam int CW   = (CH_W > 0) ? CH_W : 1;

  logic [DIV_W-1:0] sys, sys_nx;
  logic [1:0]       reg_sel;
  logic [CW-1:0]    ch;
  logic             ch_ok, wr_hit, div_wr;
  logic [3:0]       taps;

  logic [7:0] tima_a [NUM_CH];
  logic [7:0] tma_a  [NUM_CH];
  logic [2:0] tac_a  [NUM_CH];

  assign reg_sel = cpu_addr[1:0];

  generate
    if (CH_W == 0) begin : g_one_ch
      assign ch = '0;
    end else begin : g_multi_ch
      assign ch = cpu_addr[AW-1:2];
    end
  endgenerate

  assign ch_ok  = (32'(ch) < 32'(NUM_CH));
  assign wr_hit = cpu_sel & cpu_wr & ch_ok;
  assign div_wr = wr_hit & (reg_sel == REG_DIV);

  // A DIV write clears the counter that same clk instead of incrementing it.
  assign sys_nx = div_wr ? '0 : sys + DIV_W'(1);
  assign taps   = {sys_nx[TAP3], sys_nx[TAP2], sys_nx[TAP1], sys_nx[TAP0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sys <= '0;
    else          sys <= sys_nx;
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ch_hit;
      assign ch_hit = wr_hit & (32'(ch) == c);

      timer_channel #(
        .RELOAD_DLY(RELOAD_DLY)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .taps    (taps),
        .tima_wr (ch_hit & (reg_sel == REG_TIMA)),
        .tma_wr  (ch_hit & (reg_sel == REG_TMA)),
        .tac_wr  (ch_hit & (reg_sel == REG_TAC)),
        .cpu_di  (cpu_di),
        .tima    (tima_a[c]),
        .tma     (tma_a[c]),
        .tac     (tac_a[c]),
        .irq     (irq[c])
      );
    end
  endgenerate

  always_comb begin
    cpu_do = 8'hFF;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && (32'(ch) == c)) begin
        case (reg_sel)
          REG_DIV:  cpu_do = sys[DIV_W-1 -: 8];
          REG_TIMA: cpu_do = tima_a[c];
          REG_TMA:  cpu_do = tma_a[c];
          default:  cpu_do = {5'b11111, tac_a[c]};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - scoreboard bench for timer_multi against a behavioural model
module tb_timer_multi;

  localparam int NCH  = 3;
  localparam int RDLY = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_sel = 1'b0;
  logic [3:0] cpu_addr = '0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_di = '0;
  logic [7:0] cpu_do;
  logic [NCH-1:0] irq;

  timer_multi #(.NUM_CH(NCH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_sel  (cpu_sel),
    .cpu_addr (cpu_addr),
    .cpu_wr   (cpu_wr),
    .cpu_di   (cpu_di),
    .cpu_do   (cpu_do),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: values visible during the current clk.
  int m_sys;
  int m_tima [NCH];
  int m_tma  [NCH];
  int m_tac  [NCH];
  bit m_sq   [NCH];
  int m_ovf  [NCH];   // remaining clks of TIMA=00 after an overflow, 0 = none
  bit m_rel  [NCH];   // this clk is the reload clk

  int rd_q[$];
  int irq_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tap_bit(input int sel);
    case (sel)
      0: return 9;
      1: return 3;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_sys = 0;
    for (int c = 0; c < NCH; c++) begin
      m_tima[c] = 0; m_tma[c] = 0; m_tac[c] = 0;
      m_sq[c] = 0; m_ovf[c] = 0; m_rel[c] = 0;
    end
  endtask

  function automatic int model_read(input int addr);
    int ch, r;
    ch = addr >> 2;
    r  = addr & 3;
    if (ch >= NCH) return 8'hFF;
    case (r)
      0: return (m_sys >> 8) & 8'hFF;
      1: return m_tima[ch];
      2: return m_tma[ch];
      default: return 8'hF8 | m_tac[ch];
    endcase
  endfunction

  function automatic int model_irq();
    int v = 0;
    for (int c = 0; c < NCH; c++) if (m_rel[c]) v |= (1 << c);
    return v;
  endfunction

  task automatic model_step(input bit sel, input bit wr, input int addr, input int di);
    int ch, r, tac_n;
    bit w, wt, s, inc;
    ch = addr >> 2;
    r  = addr & 3;
    w  = sel && wr && (ch < NCH);
    m_sys = (w && r == 0) ? 0 : (m_sys + 1) % 65536;
    for (int c = 0; c < NCH; c++) begin
      wt    = w && (ch == c);
      tac_n = (wt && r == 3) ? (di & 7) : m_tac[c];
      s     = ((tac_n >> 2) & 1) && ((m_sys >> tap_bit(tac_n & 3)) & 1);
      inc   = m_sq[c] && !s;
      m_sq[c] = s;
      if (m_rel[c]) begin
        m_rel[c] = 0;
        if (wt && r == 2) m_tima[c] = di;
      end else if (m_ovf[c] > 0) begin
        if (wt && r == 1) begin
          m_tima[c] = di;
          m_ovf[c]  = 0;
        end else begin
          m_ovf[c]--;
          if (m_ovf[c] == 0) begin
            m_tima[c] = m_tma[c];
            m_rel[c]  = 1;
          end
        end
      end else begin
        if (wt && r == 1) m_tima[c] = di;
        else if (inc) begin
          if (m_tima[c] == 255) begin
            m_tima[c] = 0;
            m_ovf[c]  = RDLY;
          end else m_tima[c]++;
        end
      end
      if (wt && r == 2) m_tma[c] = di;
      m_tac[c] = tac_n;
    end
  endtask

  // One bus clk, entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit sel, input bit wr, input int addr, input int di,
                     input bit use_k, input int k);
    cpu_sel  = sel;
    cpu_wr   = wr;
    cpu_addr = 4'(addr);
    cpu_di   = 8'(di);
    if (sel && !wr) rd_q.push_back(use_k ? k : model_read(addr));
    irq_q.push_back(model_irq());
    @(posedge clk);
    model_step(sel, wr, addr, di);
    #1;
  endtask

  task automatic rd(input int addr);             cyc(1, 0, addr, 0, 0, 0);  endtask
  task automatic rdk(input int addr, input int k); cyc(1, 0, addr, 0, 1, k); endtask
  task automatic wr(input int addr, input int d); cyc(1, 1, addr, d, 0, 0);  endtask
  task automatic idle();                         cyc(0, 0, 0, 0, 0, 0);     endtask

  // Monitor: compares every clk's irq and every bus read against the queues.
  always @(negedge clk) begin
    if (irq_q.size() > 0) chk("irq", int'(irq), irq_q.pop_front());
    if (reset_n && cpu_sel && !cpu_wr) begin
      if (rd_q.size() == 0) chk("rd_underflow", 1, 0);
      else chk($sformatf("rd_addr%0h", cpu_addr), int'(cpu_do), rd_q.pop_front());
    end
  end

  initial begin
    int op, a, d;
    bit ok;
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    model_step(0, 0, 0, 0);
    #1;

    // Reset values
    rdk(0, 8'h00); rdk(1, 8'h00); rdk(2, 8'h00); rdk(3, 8'hF8); rdk(7, 8'hF8);

    // Basic counting on the fast tap
    wr(3, 8'h05); wr(1, 8'h00);
    for (int i = 0; i < 300; i++) rd(1);

    // Overflow with reload from TMA
    wr(2, 8'hF0); wr(1, 8'hFF);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (m_rel[0]) begin rdk(1, 8'hF0); ok = 1; end else rd(1);
    end
    chk("wait_reload1", ok, 1);
    for (int i = 0; i < 20; i++) rd(1);

    // TIMA write inside the 00 window cancels the reload
    wr(1, 8'hFF);
    for (int i = 0; i < 100 && m_ovf[0] != 2; i++) rd(1);
    chk("wait_ovf2", m_ovf[0], 2);
    wr(1, 8'h55); rdk(1, 8'h55);
    for (int i = 0; i < 10; i++) rd(1);

    // TIMA write in the reload clk is ignored
    wr(1, 8'hFF);
    for (int i = 0; i < 100 && !m_rel[0]; i++) rd(1);
    chk("wait_reload2", m_rel[0], 1);
    wr(1, 8'h33); rdk(1, 8'hF0);

    // TMA write in the reload clk lands in TIMA too
    wr(1, 8'hFF);
    for (int i = 0; i < 100 && !m_rel[0]; i++) rd(1);
    chk("wait_reload3", m_rel[0], 1);
    wr(2, 8'h77); rdk(1, 8'h77); rdk(2, 8'h77);
    wr(2, 8'hF0);

    // DIV write while tap high -> one increment; while low -> none
    for (int i = 0; i < 40 && (m_sys & 15) != 8; i++) idle();
    chk("wait_sys8", m_sys & 15, 8);
    wr(1, 8'h20); wr(0, 8'hA5); rdk(1, 8'h21); rdk(0, 8'h00);
    for (int i = 0; i < 40 && (m_sys & 15) != 0; i++) idle();
    chk("wait_sys0", m_sys & 15, 0);
    wr(1, 8'h20); wr(0, 8'h00); rdk(1, 8'h20);

    // Two channels at different rates, DIV aliases, absent channel
    wr(3, 8'h04); wr(7, 8'h07); wr(5, 8'h00); wr(1, 8'h00);
    for (int i = 0; i < 1100; i++) begin
      case (i % 8)
        0, 2, 4: rd(1);
        1, 3, 5: rd(5);
        6:       rd((i % 16 < 8) ? 0 : 4);
        default: rdk(12 + (i % 4), 8'hFF);
      endcase
    end
    wr(13, 8'h12); wr(14, 8'h34); rd(1); rd(5); rd(0);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      op = $urandom_range(0, 99);
      a  = $urandom_range(0, NCH - 1);
      d  = $urandom_range(0, 255);
      if (op < 40)      rd($urandom_range(0, 15));
      else if (op < 60) idle();
      else if (op < 75) wr(a * 4 + 1, ($urandom_range(0, 1) != 0) ? $urandom_range(252, 255) : d);
      else if (op < 85) wr(a * 4 + 2, d);
      else if (op < 95) wr(a * 4 + 3, ($urandom_range(0, 3) != 0) ? (4 | (d & 3)) : d);
      else if (op < 98) wr(a * 4 + 0, d);
      else              wr($urandom_range(0, 15), d);
    end

    // Asynchronous reset in the reload clk
    wr(3, 8'h05); wr(2, 8'hF0); wr(1, 8'hFF);
    for (int i = 0; i < 100 && !m_rel[0]; i++) rd(1);
    chk("wait_reload4", m_rel[0], 1);
    cpu_sel = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'd1;
    #1 reset_n = 1'b0;
    #1 chk("rst_irq", int'(irq), 0);
    chk("rst_tima", int'(cpu_do), 0);
    cpu_addr = 4'd2;
    #1 chk("rst_tma", int'(cpu_do), 0);
    cpu_sel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    model_step(0, 0, 0, 0);
    #1;
    rdk(1, 8'h00); rdk(3, 8'hF8); rdk(0, 8'h00);
    wr(3, 8'h05);
    for (int i = 0; i < 200; i++) rd(1);

    idle(); idle();
    chk("queues_drained", rd_q.size() + irq_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
